// File: rtl/ifmap_row_packer_pkg.sv
// Shared types and constants for the IFMap row packer: FSM states, entry flag
// positions and default widths.
package ifmap_row_packer_pkg;

  localparam int DEF_DATA_WIDTH  = 16;
  localparam int DEF_IFMAP_WIDTH = DEF_DATA_WIDTH + 2;
  localparam int DEF_PAR_WRITE   = 4;
  localparam int DEF_LEN_WIDTH   = 8;

  localparam int START_ROW_BIT = DEF_IFMAP_WIDTH - 1;
  localparam int END_ROW_BIT   = DEF_IFMAP_WIDTH - 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PACK  = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/ifmap_row_packer_hold_reg.sv
// Output holding register for one packed word: loads a completed group and
// presents it to the FIFO until written.
module pack_hold_reg #(
  parameter int W = 72
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         in_valid_i,
  input  logic [W-1:0] in_data_i,
  output logic         in_ready_o,
  input  logic         buf_ready_i,
  output logic         out_valid_o,
  output logic         buf_wen_o,
  output logic [W-1:0] buf_din_o
);

  logic         valid_q;
  logic [W-1:0] data_q;

  assign buf_wen_o   = valid_q & buf_ready_i;
  // A new group may land in the same cycle the held one drains.
  assign in_ready_o  = ~valid_q | buf_ready_i;
  assign out_valid_o = valid_q;
  assign buf_din_o   = data_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (in_valid_i) begin
      valid_q <= 1'b1;
      data_q  <= in_data_i;
    end else if (buf_wen_o) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end
  end

endmodule

// File: rtl/ifmap_row_packer.sv
// Packs a row-structured pixel stream into PAR_WRITE-wide IFMap FIFO words,
// tagging each entry with start_row/end_row flags derived from the column count.
module ifmap_row_packer
  import ifmap_row_packer_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int IFMAP_WIDTH = DEF_IFMAP_WIDTH,
  parameter int PAR_WRITE   = DEF_PAR_WRITE,
  parameter int LEN_WIDTH   = DEF_LEN_WIDTH
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic                            start,
  input  logic [LEN_WIDTH-1:0]            cfg_row_len,
  input  logic [LEN_WIDTH-1:0]            cfg_num_rows,
  input  logic                            s_valid,
  input  logic [DATA_WIDTH-1:0]           s_data,
  input  logic                            s_last,
  output logic                            s_ready,
  input  logic                            buf_ready,
  output logic                            buf_wen,
  output logic [IFMAP_WIDTH*PAR_WRITE-1:0] buf_din,
  output logic                            busy,
  output logic                            done,
  output logic                            row_err
);

  localparam int SROW   = IFMAP_WIDTH - 1;
  localparam int EROW   = IFMAP_WIDTH - 2;
  localparam int LANE_W = (PAR_WRITE > 1) ? $clog2(PAR_WRITE) : 1;

  state_e                                state_q;
  logic [LEN_WIDTH-1:0]                  row_len_q, num_rows_q, col_q, row_q;
  logic [LANE_W-1:0]                     lane_q;
  logic [PAR_WRITE-1:0][IFMAP_WIDTH-1:0] lanes_q, grp;
  logic                                  row_err_q;
  logic [IFMAP_WIDTH-1:0]                entry;
  logic accept, grp_done, last_col, last_row, cfg_ok;
  logic hold_in_ready, hold_valid;

  assign last_col = (col_q == row_len_q - LEN_WIDTH'(1));
  assign last_row = (row_q == num_rows_q - LEN_WIDTH'(1));
  assign grp_done = (lane_q == LANE_W'(PAR_WRITE - 1));
  assign cfg_ok   = (cfg_row_len != '0) && (cfg_num_rows != '0) &&
                    ((cfg_row_len % LEN_WIDTH'(PAR_WRITE)) == '0);

  // Only the group-completing pixel needs room in the holding register.
  assign s_ready = (state_q == PACK) && !(grp_done && !hold_in_ready);
  assign accept  = s_valid & s_ready;

  always_comb begin
    entry                   = '0;
    entry[DATA_WIDTH-1:0]   = s_data;
    entry[EROW]             = last_col;
    entry[SROW]             = (col_q == '0);
  end

  always_comb begin
    grp                = lanes_q;
    grp[PAR_WRITE-1]   = entry;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      row_len_q  <= '0;
      num_rows_q <= '0;
      col_q      <= '0;
      row_q      <= '0;
      lane_q     <= '0;
      lanes_q    <= '0;
      row_err_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            if (cfg_ok) begin
              row_len_q  <= cfg_row_len;
              num_rows_q <= cfg_num_rows;
              col_q      <= '0;
              row_q      <= '0;
              lane_q     <= '0;
              row_err_q  <= 1'b0;
              state_q    <= PACK;
            end else begin
              row_err_q  <= 1'b1;
            end
          end
        end
        PACK: begin
          if (accept) begin
            lanes_q[lane_q] <= entry;
            lane_q          <= grp_done ? '0 : lane_q + LANE_W'(1);
            // Mismatched s_last is only reported; counter flags stay authoritative.
            if (s_last != last_col) row_err_q <= 1'b1;
            if (last_col) begin
              col_q <= '0;
              row_q <= row_q + LEN_WIDTH'(1);
              if (last_row) state_q <= FLUSH;
            end else begin
              col_q <= col_q + LEN_WIDTH'(1);
            end
          end
        end
        FLUSH: begin
          if (!hold_valid || buf_wen) state_q <= DONE;
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  pack_hold_reg #(
    .W (IFMAP_WIDTH*PAR_WRITE)
  ) u_hold (
    .clk         (clk),
    .rstn        (rstn),
    .in_valid_i  (accept & grp_done),
    .in_data_i   (grp),
    .in_ready_o  (hold_in_ready),
    .buf_ready_i (buf_ready),
    .out_valid_o (hold_valid),
    .buf_wen_o   (buf_wen),
    .buf_din_o   (buf_din)
  );

  assign busy    = (state_q == PACK) || (state_q == FLUSH);
  assign done    = (state_q == DONE);
  assign row_err = row_err_q;

endmodule

// File: tb/tb_ifmap_row_packer.sv
// Randomized self-checking bench for ifmap_row_packer against a queue-based
// reference model of the packed FIFO words.
module tb_ifmap_row_packer;
  import ifmap_row_packer_pkg::*;

  localparam int DW = 16;
  localparam int IW = 18;
  localparam int PW = 4;
  localparam int LW = 8;
  localparam int BW = IW*PW;

  logic          clk, rstn, start;
  logic [LW-1:0] cfg_row_len, cfg_num_rows;
  logic          s_valid, s_last, s_ready;
  logic [DW-1:0] s_data;
  logic          buf_ready, buf_wen, busy, done, row_err;
  logic [BW-1:0] buf_din;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int wr_cnt = 0;
  int done_cnt = 0;
  int last_wr = 0;
  bit rand_bp = 0;
  bit saw_block = 0;
  logic [BW-1:0] exp_q[$];
  logic [BW-1:0] wr_log[$];

  ifmap_row_packer #(
    .DATA_WIDTH(DW), .IFMAP_WIDTH(IW), .PAR_WRITE(PW), .LEN_WIDTH(LW)
  ) dut (
    .clk(clk), .rstn(rstn), .start(start),
    .cfg_row_len(cfg_row_len), .cfg_num_rows(cfg_num_rows),
    .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready),
    .buf_ready(buf_ready), .buf_wen(buf_wen), .buf_din(buf_din),
    .busy(busy), .done(done), .row_err(row_err)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every FIFO write must match the next modelled word.
  initial forever begin
    @(negedge clk);
    if (buf_wen) begin
      wr_cnt++;
      last_wr = cyc;
      wr_log.push_back(buf_din);
      if (exp_q.size() == 0) chk("wr_unexp", 128'(buf_wen), 128'(0));
      else                   chk("wr_data", 128'(buf_din), 128'(exp_q.pop_front()));
    end
    if (done) begin
      done_cnt++;
      chk("done_lat", 128'(cyc - last_wr), 128'(1));
    end
    if (busy && !s_ready && !buf_ready) saw_block = 1;
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (rand_bp) buf_ready = ($urandom_range(0, 2) != 0);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic send_pix(input logic [DW-1:0] d, input logic last);
    int  n;
    bit  acc;
    n = 0;
    s_valid = 1; s_data = d; s_last = last;
    do begin
      @(negedge clk);
      acc = s_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 300);
    if (!acc) chk("sready_to", 128'(acc), 128'(1));
    s_valid = 0; s_last = 0;
  endtask

  task automatic pulse_start(input int rl, input int rows);
    cfg_row_len = LW'(rl); cfg_num_rows = LW'(rows); start = 1;
    @(posedge clk);
    #1 start = 0;
  endtask

  task automatic run_frame(input int rl, input int rows, input int bad_col,
                           input bit stall8, input bit gaps, input bit mid_start,
                           input bit seq, input bit exp_err);
    int n, d0, w0;
    logic [BW-1:0] w;
    logic [DW-1:0] px[$];
    n = rl*rows;
    for (int i = 0; i < n; i++) px.push_back(seq ? DW'(i+1) : DW'($urandom));
    w = '0;
    for (int i = 0; i < n; i++) begin
      int col;
      col = i % rl;
      w[(i%PW)*IW +: IW] = {col == 0, col == rl-1, px[i]};
      if (i % PW == PW-1) begin exp_q.push_back(w); w = '0; end
    end
    d0 = done_cnt; w0 = wr_cnt; saw_block = 0;
    pulse_start(rl, rows);
    chk("start_busy", 128'(busy), 128'(1));
    chk("err_clr", 128'(row_err), 128'(0));
    for (int i = 0; i < n; i++) begin
      if (mid_start && i == n/2) begin
        cfg_row_len = 4; cfg_num_rows = 1; start = 1;
      end
      if (gaps && $urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      send_pix(px[i], (i % rl == rl-1) || (i % rl == bad_col));
      start = 0;
      if (stall8 && i == 7) fork
        begin
          buf_ready = 0;
          repeat (5) @(posedge clk);
          #1 buf_ready = 1;
        end
      join_none
    end
    for (int k = 0; k < 600 && done_cnt == d0; k++) @(posedge clk);
    repeat (2) @(posedge clk);
    #1;
    chk("done_once", 128'(done_cnt - d0), 128'(1));
    chk("nwr", 128'(wr_cnt - w0), 128'(n/PW));
    chk("exp_left", 128'(exp_q.size()), 128'(0));
    chk("row_err", 128'(row_err), 128'(exp_err));
    chk("idle_busy", 128'(busy), 128'(0));
    if (stall8) chk("sready_drop", 128'(saw_block), 128'(1));
    exp_q.delete();
  endtask

  initial begin
    logic [BW-1:0] w;
    int w0;
    rstn = 0; start = 0; cfg_row_len = 0; cfg_num_rows = 0;
    s_valid = 0; s_data = 0; s_last = 0; buf_ready = 1;
    #3;
    chk("rst_sready", 128'(s_ready), 128'(0));
    chk("rst_wen", 128'(buf_wen), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_done", 128'(done), 128'(0));
    chk("rst_err", 128'(row_err), 128'(0));
    chk("rst_din", 128'(buf_din), 128'(0));
    repeat (2) @(posedge clk);
    #1 rstn = 1;
    @(posedge clk);
    #1;

    // Back-to-back 8x2 frame with pixel values 1..16
    wr_log.delete();
    run_frame(8, 2, -1, 0, 0, 0, 1, 0);
    if (wr_log.size() >= 2) begin
      w = wr_log[0];
      chk("w0_lane0", 128'(w[IW-1:0]), 128'(18'h20001));
      w = wr_log[1];
      chk("w1_lane3", 128'(w[BW-1 -: IW]), 128'(18'h10008));
    end else chk("wr_log_len", 128'(wr_log.size()), 128'(2));

    // FIFO back-pressure during the second group
    run_frame(8, 2, -1, 1, 0, 0, 1, 0);

    // Illegal configurations
    w0 = wr_cnt;
    pulse_start(6, 2);
    chk("bad_len_err", 128'(row_err), 128'(1));
    chk("bad_len_busy", 128'(busy), 128'(0));
    repeat (6) @(posedge clk);
    #1 chk("bad_len_nowr", 128'(wr_cnt - w0), 128'(0));
    run_frame(4, 1, -1, 0, 0, 0, 0, 0);
    pulse_start(8, 0);
    chk("bad_rows_err", 128'(row_err), 128'(1));
    chk("bad_rows_busy", 128'(busy), 128'(0));
    run_frame(4, 1, -1, 0, 0, 0, 0, 0);
    pulse_start(0, 1);
    chk("bad_zero_err", 128'(row_err), 128'(1));

    // s_last asserted early on column 3
    run_frame(8, 1, 3, 0, 0, 0, 0, 1);

    // start while busy must be ignored
    run_frame(8, 2, -1, 0, 0, 1, 0, 0);

    // Reset mid-frame with a held group and a partial group pending
    buf_ready = 0;
    pulse_start(8, 1);
    for (int i = 0; i < 5; i++) send_pix(DW'(16'hA0 + i), 1'b0);
    rstn = 0;
    #1;
    chk("mid_rst_wen", 128'(buf_wen), 128'(0));
    chk("mid_rst_busy", 128'(busy), 128'(0));
    chk("mid_rst_din", 128'(buf_din), 128'(0));
    repeat (2) @(posedge clk);
    #1 rstn = 1; buf_ready = 1;
    w0 = wr_cnt;
    repeat (8) @(posedge clk);
    #1 chk("mid_rst_nowr", 128'(wr_cnt - w0), 128'(0));
    wr_log.delete();
    run_frame(8, 1, -1, 0, 0, 0, 1, 0);
    if (wr_log.size() >= 1) begin
      w = wr_log[0];
      chk("post_rst_w0", 128'(w), 128'({18'h00004, 18'h00003, 18'h00002, 18'h20001}));
    end else chk("post_rst_len", 128'(wr_log.size()), 128'(1));

    // Random frames with random back-pressure and input gaps
    rand_bp = 1;
    for (int t = 0; t < 8; t++)
      run_frame(4 * $urandom_range(1, 4), $urandom_range(1, 3), -1, 0, 1, 0, 0, 0);
    rand_bp = 0;
    @(posedge clk);
    #2 buf_ready = 1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
